// File: rtl/vdp_video_out.sv
// VDP native video to 480p DVI/HDMI-style raster, with 512 -> 640 horizontal
// linear interpolation read from a ping-pong line buffer.
module vdp_video_out #(
  parameter logic hs_positive = 1'b0,
  parameter logic vs_positive = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [5:0]  vdp_r,
  input  logic [5:0]  vdp_g,
  input  logic [5:0]  vdp_b,
  input  logic [10:0] vdp_hcounter,
  input  logic [10:0] vdp_vcounter,
  output logic        video_clk,
  output logic        video_de,
  output logic        video_hs,
  output logic        video_vs,
  output logic [7:0]  video_r,
  output logic [7:0]  video_g,
  output logic [7:0]  video_b
);

  function automatic logic [3:0] weight(input logic [2:0] f);
    case (f)
      3'd1:    return 4'd3;
      3'd2:    return 4'd6;
      3'd3:    return 4'd10;
      3'd4:    return 4'd13;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [5:0] lerp(input logic [5:0] a, input logic [5:0] b, input logic [3:0] w);
    logic [9:0] s;
    s = {4'b0, a} * (10'd16 - {6'b0, w}) + {4'b0, b} * {6'b0, w};
    return s[9:4];
  endfunction

  // Bank = vcounter[0]: the line being captured never collides with the line being shown.
  logic [17:0] line_buf [0:1023];
  logic [9:0]  pix_x;
  logic        wr_en;
  logic [8:0]  wr_idx;

  assign pix_x  = vdp_hcounter[10:1];
  assign wr_en  = enable && (vdp_hcounter >= 11'd272) && (vdp_hcounter <= 11'd1295);
  assign wr_idx = 9'((vdp_hcounter - 11'd272) >> 1);

  always_ff @(posedge clk) begin
    if (wr_en) line_buf[{vdp_vcounter[0], wr_idx}] <= {vdp_r, vdp_g, vdp_b};
  end

  logic [9:0]  idx_q, idx_d;
  logic [2:0]  frac_q, frac_d;
  logic [3:0]  frac_sum;
  logic        rbank_q, rbank_d, de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [8:0]  a_idx, b_idx;
  logic [17:0] rd_word;
  logic [17:0] samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic [17:0] a2_q, a2_d;
  logic [2:0]  frac2_q, frac2_d;
  logic        de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [3:0]  w2;
  logic [17:0] pix3_q, pix3_d;
  logic        de3_q, de3_d, hs3_q, hs3_d, vs3_q, vs3_d;
  logic        vclk_q, de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;

  // Sample a is fetched on the idle clk of a pixel period, sample b on the enable clk.
  assign a_idx   = (idx_q > 10'd511) ? 9'd511 : idx_q[8:0];
  assign b_idx   = (idx_q >= 10'd511) ? 9'd511 : idx_q[8:0] + 9'd1;
  assign rd_word = line_buf[{rbank_q, enable ? b_idx : a_idx}];
  assign w2      = weight(frac2_q);

  always_comb begin
    idx_d = idx_q;  frac_d = frac_q;  rbank_d = rbank_q;
    de1_d = de1_q;  hs1_d = hs1_q;    vs1_d = vs1_q;
    frac_sum = {1'b0, frac_q} + 4'd4;
    samp_a_d = enable ? samp_a_q : rd_word;
    samp_b_d = enable ? rd_word : samp_b_q;
    a2_d = a2_q;  frac2_d = frac2_q;  de2_d = de2_q;  hs2_d = hs2_q;  vs2_d = vs2_q;
    pix3_d = pix3_q;  de3_d = de3_q;  hs3_d = hs3_q;  vs3_d = vs3_q;
    de_d = de_q;  hs_d = hs_q;  vs_d = vs_q;  r_d = r_q;  g_d = g_q;  b_d = b_q;
    if (enable) begin
      // Phase accumulator: i = floor(4x/5), f = 4x mod 5, restarted at x = 0.
      if (pix_x == 10'd0) begin
        idx_d  = 10'd0;
        frac_d = 3'd0;
      end else if (frac_sum >= 4'd5) begin
        idx_d  = idx_q + 10'd1;
        frac_d = 3'(frac_sum - 4'd5);
      end else begin
        frac_d = frac_sum[2:0];
      end
      rbank_d = ~vdp_vcounter[0];
      de1_d   = (pix_x < 10'd640) && (vdp_vcounter >= 11'd24) && (vdp_vcounter <= 11'd503);
      hs1_d   = (pix_x >= 10'd648) && (pix_x <= 10'd671);
      vs1_d   = (vdp_vcounter == 11'd514) || (vdp_vcounter == 11'd515);
      a2_d    = samp_a_q;  frac2_d = frac_q;  de2_d = de1_q;  hs2_d = hs1_q;  vs2_d = vs1_q;
      pix3_d  = {lerp(a2_q[17:12], samp_b_q[17:12], w2),
                 lerp(a2_q[11:6],  samp_b_q[11:6],  w2),
                 lerp(a2_q[5:0],   samp_b_q[5:0],   w2)};
      de3_d   = de2_q;  hs3_d = hs2_q;  vs3_d = vs2_q;
      de_d    = de3_q;
      hs_d    = hs3_q ? hs_positive : ~hs_positive;
      vs_d    = vs3_q ? vs_positive : ~vs_positive;
      r_d     = de3_q ? {pix3_q[17:12], pix3_q[17:16]} : 8'd0;
      g_d     = de3_q ? {pix3_q[11:6],  pix3_q[11:10]} : 8'd0;
      b_d     = de3_q ? {pix3_q[5:0],   pix3_q[5:4]}   : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;  frac_q <= '0;  rbank_q <= 1'b0;
      de1_q <= 1'b0;  hs1_q <= 1'b0;  vs1_q <= 1'b0;
      samp_a_q <= '0;  samp_b_q <= '0;
      a2_q <= '0;  frac2_q <= '0;  de2_q <= 1'b0;  hs2_q <= 1'b0;  vs2_q <= 1'b0;
      pix3_q <= '0;  de3_q <= 1'b0;  hs3_q <= 1'b0;  vs3_q <= 1'b0;
      vclk_q <= 1'b0;  de_q <= 1'b0;  hs_q <= ~hs_positive;  vs_q <= ~vs_positive;
      r_q <= '0;  g_q <= '0;  b_q <= '0;
    end else begin
      idx_q <= idx_d;  frac_q <= frac_d;  rbank_q <= rbank_d;
      de1_q <= de1_d;  hs1_q <= hs1_d;  vs1_q <= vs1_d;
      samp_a_q <= samp_a_d;  samp_b_q <= samp_b_d;
      a2_q <= a2_d;  frac2_q <= frac2_d;  de2_q <= de2_d;  hs2_q <= hs2_d;  vs2_q <= vs2_d;
      pix3_q <= pix3_d;  de3_q <= de3_d;  hs3_q <= hs3_d;  vs3_q <= vs3_d;
      vclk_q <= enable;  de_q <= de_d;  hs_q <= hs_d;  vs_q <= vs_d;
      r_q <= r_d;  g_q <= g_d;  b_q <= b_d;
    end
  end

  assign video_clk = vclk_q;
  assign video_de  = de_q;
  assign video_hs  = hs_q;
  assign video_vs  = vs_q;
  assign video_r   = r_q;
  assign video_g   = g_q;
  assign video_b   = b_q;

endmodule

// File: tb/tb_vdp_video_out.sv
// Bench for vdp_video_out: raster/interpolation model with a 6-clk expected queue,
// per-line statistics and literal pins for colour, ramp and sync polarity.
module tb_vdp_video_out;

  localparam int PH_FRAME = 0, PH_FULL = 1, PH_RAMP = 2, PH_RAND = 3;
  localparam int M_ZERO = 0, M_CONST = 1, M_RAMP = 2, M_RAND = 3;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [5:0]  vdp_r, vdp_g, vdp_b;
  logic [10:0] vdp_hcounter, vdp_vcounter;
  logic        n_clk, n_de, n_hs, n_vs, p_clk, p_de, p_hs, p_vs;
  logic [7:0]  n_r, n_g, n_b, p_r, p_g, p_b;

  always #5 clk = ~clk;

  vdp_video_out #(.hs_positive(1'b0), .vs_positive(1'b0)) dut_n (
    .clk(clk), .reset(reset), .enable(enable), .vdp_r(vdp_r), .vdp_g(vdp_g), .vdp_b(vdp_b),
    .vdp_hcounter(vdp_hcounter), .vdp_vcounter(vdp_vcounter), .video_clk(n_clk), .video_de(n_de),
    .video_hs(n_hs), .video_vs(n_vs), .video_r(n_r), .video_g(n_g), .video_b(n_b));

  vdp_video_out #(.hs_positive(1'b1), .vs_positive(1'b1)) dut_p (
    .clk(clk), .reset(reset), .enable(enable), .vdp_r(vdp_r), .vdp_g(vdp_g), .vdp_b(vdp_b),
    .vdp_hcounter(vdp_hcounter), .vdp_vcounter(vdp_vcounter), .video_clk(p_clk), .video_de(p_de),
    .video_hs(p_hs), .video_vs(p_vs), .video_r(p_r), .video_g(p_g), .video_b(p_b));

  typedef struct packed {
    int          due;
    logic [9:0]  x;
    logic [10:0] y;
    logic [1:0]  phase;
    logic        de, hs, vs, rgb_chk;
    logic [7:0]  r, g, b;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  int ctx_x = -1, ctx_y = -1;
  int cyc = 0, phase = PH_FRAME;
  logic last_en = 1'b0, last_rst = 1'b1;
  bit started = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (x=%0d y=%0d t=%0t)", name, act, exp, ctx_x, ctx_y, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [17:0] mdl_buf [0:1][0:511];
  bit          mdl_val [0:1][0:511];
  int          wtab [0:4] = '{0, 3, 6, 10, 13};
  int          m_h, m_v, m_x, m_i, m_f, m_w, m_bi, m_rb, prev_x = 0;
  bit          run_ok = 0;
  logic [17:0] m_a, m_b;
  exp_t        m_e;

  function automatic int mix8(input int a, input int b, input int w);
    int c;
    c = (a * (16 - w) + b * w) / 16;
    return c * 4 + c / 16;
  endfunction

  always @(posedge clk) begin
    cyc++;
    started  = 1;
    last_en  = enable;
    last_rst = reset;
    if (!reset && enable) begin
      m_h = vdp_hcounter;  m_v = vdp_vcounter;  m_x = m_h / 2;
      if (m_h >= 272 && m_h <= 1295) begin
        mdl_buf[m_v % 2][(m_h - 272) / 2] = {vdp_r, vdp_g, vdp_b};
        mdl_val[m_v % 2][(m_h - 272) / 2] = 1;
      end
      if (m_x == 0) run_ok = 1;
      else if (m_x != prev_x + 1) run_ok = 0;
      prev_x = m_x;
      m_e = '0;
      m_e.due = cyc + 6;  m_e.x = 10'(m_x);  m_e.y = 11'(m_v);  m_e.phase = 2'(phase);
      m_e.de = (m_x < 640) && (m_v >= 24) && (m_v <= 503);
      m_e.hs = (m_x >= 648) && (m_x <= 671);
      m_e.vs = (m_v == 514) || (m_v == 515);
      if (m_e.de) begin
        m_i  = (4 * m_x) / 5;  m_f = (4 * m_x) % 5;  m_w = wtab[m_f];
        m_bi = (m_i + 1 > 511) ? 511 : m_i + 1;
        m_rb = 1 - (m_v % 2);
        if (run_ok && mdl_val[m_rb][m_i] && mdl_val[m_rb][m_bi]) begin
          m_a = mdl_buf[m_rb][m_i];  m_b = mdl_buf[m_rb][m_bi];
          m_e.rgb_chk = 1;
          m_e.r = 8'(mix8(int'(m_a[17:12]), int'(m_b[17:12]), m_w));
          m_e.g = 8'(mix8(int'(m_a[11:6]),  int'(m_b[11:6]),  m_w));
          m_e.b = 8'(mix8(int'(m_a[5:0]),   int'(m_b[5:0]),   m_w));
        end
      end
      exp_q.push_back(m_e);
    end
  end

  // ---------------- compare process ----------------
  int de_cnt [0:523], pix_cnt [0:523], hs_cnt [0:523], hs_first [0:523], vs_cnt [0:523];
  int ramp_lit [0:5] = '{0, 0, 4, 8, 12, 16};
  exp_t c_e;

  task automatic clear_stats();
    for (int y = 0; y < 524; y++) begin
      de_cnt[y] = 0;  pix_cnt[y] = 0;  hs_cnt[y] = 0;  hs_first[y] = -1;  vs_cnt[y] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("video_clk_n", int'(n_clk), last_rst ? 0 : int'(last_en));
      chk("video_clk_p", int'(p_clk), last_rst ? 0 : int'(last_en));
    end
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      c_e = exp_q.pop_front();
      ctx_x = int'(c_e.x);  ctx_y = int'(c_e.y);
      chk("latency", cyc, c_e.due);
      chk("de_n", int'(n_de), int'(c_e.de));
      chk("de_p", int'(p_de), int'(c_e.de));
      chk("hs_n", int'(n_hs), c_e.hs ? 0 : 1);
      chk("vs_n", int'(n_vs), c_e.vs ? 0 : 1);
      chk("hs_p", int'(p_hs), c_e.hs ? 1 : 0);
      chk("vs_p", int'(p_vs), c_e.vs ? 1 : 0);
      if (!c_e.de) begin
        chk("blank_rgb_n", int'({n_r, n_g, n_b}), 0);
        chk("blank_rgb_p", int'({p_r, p_g, p_b}), 0);
      end else if (c_e.rgb_chk) begin
        chk("r_n", int'(n_r), int'(c_e.r));
        chk("g_n", int'(n_g), int'(c_e.g));
        chk("b_n", int'(n_b), int'(c_e.b));
        chk("rgb_p", int'({p_r, p_g, p_b}), int'({c_e.r, c_e.g, c_e.b}));
      end
      if (int'(c_e.phase) == PH_FULL && c_e.de) begin
        chk("const_r", int'(n_r), 255);
        chk("const_g", int'(n_g), 0);
        chk("const_b", int'(n_b), 130);
      end
      if (int'(c_e.phase) == PH_RAMP && c_e.y == 11'd101) begin
        if (c_e.x <= 10'd5) begin
          chk("ramp_r", int'(n_r), ramp_lit[int'(c_e.x)]);
          chk("ramp_g", int'(n_g), ramp_lit[int'(c_e.x)]);
          chk("ramp_b", int'(n_b), ramp_lit[int'(c_e.x)]);
        end else if (c_e.x == 10'd639) begin
          chk("ramp_last", int'({n_r, n_g, n_b}), int'({8'd255, 8'd255, 8'd255}));
        end
      end
      if (c_e.y < 11'd524) begin
        pix_cnt[c_e.y]++;
        if (n_de) de_cnt[c_e.y]++;
        if (!n_hs) begin
          hs_cnt[c_e.y]++;
          if (hs_first[c_e.y] < 0) hs_first[c_e.y] = int'(c_e.x);
        end
        if (!n_vs) vs_cnt[c_e.y]++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input int h, input int v, input int mode);
    int k;
    vdp_hcounter = 11'(h);
    vdp_vcounter = 11'(v);
    enable = (h % 2 == 0);
    k = (h >= 272) ? ((h - 272) / 2) % 64 : 0;
    case (mode)
      M_CONST: begin vdp_r = 6'd63; vdp_g = 6'd0; vdp_b = 6'd32; end
      M_RAMP:  begin vdp_r = 6'(k); vdp_g = 6'(k); vdp_b = 6'(k); end
      M_RAND:  begin
        vdp_r = 6'($urandom_range(0, 63));
        vdp_g = 6'($urandom_range(0, 63));
        vdp_b = 6'($urandom_range(0, 63));
      end
      default: begin vdp_r = 6'd0; vdp_g = 6'd0; vdp_b = 6'd0; end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic run_line(input int v, input int mode);
    for (int h = 0; h < 1368; h++) drive(h, v, mode);
  endtask

  int nde, fde, lde, nvs, fvs;
  int full_lines [0:3] = '{24, 25, 101, 201};

  initial begin
    reset = 1'b1;  enable = 1'b0;
    vdp_hcounter = '0;  vdp_vcounter = '0;  vdp_r = '0;  vdp_g = '0;  vdp_b = '0;
    clear_stats();

    for (int h = 0; h < 3; h++) drive(h, 0, M_ZERO);
    ctx_x = -1;  ctx_y = -1;
    chk("rst_rgb_n", int'({n_r, n_g, n_b}), 0);
    chk("rst_de_n", int'(n_de), 0);
    chk("rst_vclk_n", int'(n_clk), 0);
    chk("rst_hs_n", int'(n_hs), 1);
    chk("rst_vs_n", int'(n_vs), 1);
    chk("rst_rgb_p", int'({p_r, p_g, p_b}), 0);
    chk("rst_de_p", int'(p_de), 0);
    chk("rst_hs_p", int'(p_hs), 0);
    chk("rst_vs_p", int'(p_vs), 0);
    reset = 1'b0;

    // Whole frame, short segment of every line: vertical DE/VS placement.
    phase = PH_FRAME;
    for (int y = 0; y < 524; y++)
      for (int h = 0; h < 28; h++) drive(h, y, M_RAND);
    for (int h = 28; h < 44; h++) drive(h, 523, M_RAND);
    nde = 0;  fde = -1;  lde = -1;  nvs = 0;  fvs = -1;
    for (int y = 0; y < 524; y++) begin
      if (de_cnt[y] > 0) begin
        nde++;
        if (fde < 0) fde = y;
        lde = y;
      end
      if (vs_cnt[y] > 0) begin
        nvs++;
        if (fvs < 0) fvs = y;
      end
    end
    ctx_x = -1;  ctx_y = -1;
    chk("de_lines", nde, 480);
    chk("first_de_line", fde, 24);
    chk("last_de_line", lde, 503);
    chk("vs_lines", nvs, 2);
    chk("first_vs_line", fvs, 514);
    clear_stats();

    // Full lines: constant colour, ramp, random.
    phase = PH_FULL;
    for (int y = 22; y < 26; y++) run_line(y, M_CONST);
    phase = PH_RAMP;
    run_line(100, M_RAMP);
    run_line(101, M_RAMP);
    phase = PH_RAND;
    run_line(200, M_RAND);
    run_line(201, M_RAND);
    for (int h = 0; h < 16; h++) drive(h, 202, M_RAND);

    for (int j = 0; j < 4; j++) begin
      ctx_x = -1;  ctx_y = full_lines[j];
      chk("de_per_line", de_cnt[full_lines[j]], 640);
      chk("pix_per_line", pix_cnt[full_lines[j]], 684);
      chk("hs_width", hs_cnt[full_lines[j]], 24);
      chk("hs_start", hs_first[full_lines[j]], 648);
      chk("vs_in_active", vs_cnt[full_lines[j]], 0);
    end
    for (int y = 22; y < 24; y++) begin
      ctx_x = -1;  ctx_y = y;
      chk("de_blank_line", de_cnt[y], 0);
      chk("pix_blank_line", pix_cnt[y], 684);
      chk("hs_blank_line", hs_cnt[y], 24);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
